// File: rtl/fp_max_reduce_pkg.sv
// Shared types and constants for the streaming max-reduction block.
package fp_max_pkg;

    // Sequencer states: waiting for a start, folding elements, holding the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default field layout (IEEE single precision).
    localparam int DATA_WIDTH_DEF = 32;
    localparam int EXPO_WIDTH_DEF = 8;
    localparam int MANT_WIDTH_DEF = 23;

    // Bit pattern of negative infinity: sign and exponent all ones, mantissa zero.
    // Returned right-aligned in 64 bits; callers truncate to their operand width.
    function automatic logic [63:0] neg_inf_bits(input int expo_w, input int mant_w);
        logic [63:0] ones;
        ones = (64'd1 << (expo_w + 1)) - 64'd1;
        return ones << mant_w;
    endfunction

    localparam logic [DATA_WIDTH_DEF-1:0] NEG_INF =
        DATA_WIDTH_DEF'(neg_inf_bits(EXPO_WIDTH_DEF, MANT_WIDTH_DEF));

endpackage

// File: rtl/fp_max_reduce_if.sv
// Control, input-stream and result-stream signals of the max-reduction block.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and data
// stable until that edge; ready never depends combinationally on valid.
interface fp_max_reduce_if
    import fp_max_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) ();
    logic                  start_i;
    logic [LEN_WIDTH-1:0]  len_i;
    logic                  abort_i;
    logic                  busy_o;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [LEN_WIDTH-1:0]  out_idx_o;
    state_t                dbg_state;

    modport slave (
        input  start_i, len_i, abort_i, in_valid_i, in_data_i, out_ready_i,
        output busy_o, in_ready_o, out_valid_o, out_data_o, out_idx_o, dbg_state
    );

    modport master (
        output start_i, len_i, abort_i, in_valid_i, in_data_i, out_ready_i,
        input  busy_o, in_ready_o, out_valid_o, out_data_o, out_idx_o, dbg_state
    );
endinterface

// File: rtl/fp_max_reduce_compare.sv
// Combinational floating-point max of two operands by sign and raw magnitude.
// NaN, infinity and signed zero are treated as plain bit patterns.
module fp_compare #(
    parameter int DATA_WIDTH = 32,
    parameter int EXPO_WIDTH = 8,
    parameter int MANT_WIDTH = 23
) (
    input  logic [DATA_WIDTH-1:0] oprand_A,
    input  logic [DATA_WIDTH-1:0] oprand_B,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int MAG_W = EXPO_WIDTH + MANT_WIDTH;

    logic             sign_a;
    logic             sign_b;
    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;

    assign sign_a = oprand_A[DATA_WIDTH-1];
    assign sign_b = oprand_B[DATA_WIDTH-1];
    assign mag_a  = oprand_A[MAG_W-1:0];
    assign mag_b  = oprand_B[MAG_W-1:0];

    // Positive beats negative; equal positives pick B, equal negatives pick A.
    always_comb begin
        result = oprand_B;
        if (sign_a != sign_b) begin
            result = sign_a ? oprand_B : oprand_A;
        end else if (!sign_a) begin
            result = (mag_a > mag_b) ? oprand_A : oprand_B;
        end else begin
            result = (mag_b < mag_a) ? oprand_B : oprand_A;
        end
    end
endmodule

// File: rtl/fp_max_reduce.sv
// Streaming max reduction: folds len elements into a running maximum at one
// element per cycle and presents the maximum plus its index on a result stream.
module fp_max_reduce
    import fp_max_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EXPO_WIDTH = 8,
    parameter int MANT_WIDTH = 23,
    parameter int LEN_WIDTH  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    fp_max_reduce_if.slave  bus
);
    localparam logic [DATA_WIDTH-1:0] NEG_INF_W =
        DATA_WIDTH'(neg_inf_bits(EXPO_WIDTH, MANT_WIDTH));

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] cmp_res;
    logic [LEN_WIDTH-1:0]  idx_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  in_hs;

    // Handshakes only count in ACCUM; abort discards a coincident one.
    assign in_hs = bus.in_valid_i && (state_q == ACCUM) && !bus.abort_i;

    fp_compare #(
        .DATA_WIDTH(DATA_WIDTH),
        .EXPO_WIDTH(EXPO_WIDTH),
        .MANT_WIDTH(MANT_WIDTH)
    ) u_cmp (
        .oprand_A(acc_q),
        .oprand_B(bus.in_data_i),
        .result  (cmp_res)
    );

    assign bus.busy_o      = (state_q != IDLE);
    assign bus.in_ready_o  = (state_q == ACCUM);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.out_data_o  = acc_q;
    assign bus.out_idx_o   = idx_q;
    assign bus.dbg_state   = state_q;

    // Next state: abort wins over everything, a zero-length start goes straight to DONE.
    always_comb begin
        state_d = state_q;
        if (bus.abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_d = (bus.len_i == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_hs && (rem_q == LEN_WIDTH'(1))) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run bookkeeping plus the running maximum and its index; the first element
    // loads directly so the comparator never sees a stale accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            rem_q <= '0;
        end else if (!bus.abort_i) begin
            if ((state_q == IDLE) && bus.start_i) begin
                rem_q <= bus.len_i;
                cnt_q <= '0;
                if (bus.len_i == '0) begin
                    acc_q <= NEG_INF_W;
                    idx_q <= '0;
                end
            end else if (in_hs) begin
                rem_q <= rem_q - LEN_WIDTH'(1);
                cnt_q <= cnt_q + LEN_WIDTH'(1);
                if (cnt_q == '0) begin
                    acc_q <= bus.in_data_i;
                    idx_q <= '0;
                end else begin
                    acc_q <= cmp_res;
                    if (cmp_res != acc_q) begin
                        idx_q <= cnt_q;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_max_reduce.sv
// Bench for fp_max_reduce: table of reduction runs plus hand-written abort,
// reset and full-length sequences, checked through an expected-result queue.
module tb_fp_max_reduce;
    import fp_max_pkg::*;

    localparam int DW = 32;
    localparam int LW = 16;

    typedef struct {
        int              len;
        logic [0:7][31:0] data;
        logic [31:0]     exp_data;
        logic [15:0]     exp_idx;
        int              gap;
        int              hold;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];
    logic [DW+LW-1:0] exp_q[$];

    fp_max_reduce_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    fp_max_reduce #(
        .DATA_WIDTH(DW),
        .EXPO_WIDTH(8),
        .MANT_WIDTH(23),
        .LEN_WIDTH (LW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int len, input logic [0:7][31:0] d, input logic [31:0] ed,
                           input logic [15:0] ei, input int gap, input int hold);
        vec_t v;
        v.len = len; v.data = d; v.exp_data = ed; v.exp_idx = ei; v.gap = gap; v.hold = hold;
        vecs.push_back(v);
    endtask

    // Takes the result from DONE: pops the scoreboard, handshakes, checks return to IDLE.
    task automatic collect(input string name);
        logic [DW+LW-1:0] exp;
        check({name, "_out_valid"}, 64'(bus.out_valid_o), 64'd1);
        bus.out_ready_i = 1'b1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_scoreboard: got result with empty expected queue", name);
        end else begin
            exp = exp_q.pop_front();
            check({name, "_result"}, 64'({bus.out_data_o, bus.out_idx_o}), 64'(exp));
        end
        step();
        bus.out_ready_i = 1'b0;
        check({name, "_idle_after"}, 64'({bus.busy_o, bus.out_valid_o, 2'(bus.dbg_state)}),
              64'({1'b0, 1'b0, 2'(IDLE)}));
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int w;
        bus.start_i = 1'b1;
        bus.len_i   = LW'(v.len);
        exp_q.push_back({v.exp_data, v.exp_idx});
        check({name, "_idle_ready"}, 64'(bus.in_ready_o), 64'd0);
        step();
        bus.start_i = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) step();
            end
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = v.data[i];
            w = 0;
            while (!bus.in_ready_o && w < 4) begin
                step();
                w++;
            end
            if (!bus.in_ready_o) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_ready_timeout: in_ready 0 expected 1", name);
            end
            step();
            bus.in_valid_i = 1'b0;
        end
        check({name, "_latency"}, 64'({bus.out_valid_o, bus.in_ready_o}), 64'({1'b1, 1'b0}));
        for (int h = 0; h < v.hold; h++) begin
            check({name, "_hold"}, 64'({bus.out_valid_o, bus.out_data_o, bus.out_idx_o}),
                  64'({1'b1, v.exp_data, v.exp_idx}));
            bus.start_i = (h == 1);
            bus.len_i   = LW'(2);
            step();
            bus.start_i = 1'b0;
        end
        collect(name);
    endtask

    initial begin
        logic [31:0] d;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.len_i = '0; bus.abort_i = 1'b0;
        bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.out_ready_i = 1'b0;

        add_vec(4, {32'h3F800000, 32'hC0400000, 32'h40000000, 32'h3F000000, 128'h0},
                32'h40000000, 16'd2, 0, 0);
        add_vec(3, {32'hBF800000, 32'hBF800000, 32'hC0000000, 160'h0}, 32'hBF800000, 16'd0, 0, 0);
        add_vec(2, {32'h80000000, 32'h00000000, 192'h0}, 32'h00000000, 16'd1, 0, 0);
        add_vec(2, {32'h3F800000, 32'h3F800000, 192'h0}, 32'h3F800000, 16'd0, 0, 0);
        add_vec(0, {256'h0}, 32'hFF800000, 16'd0, 0, 0);
        add_vec(1, {32'hC1200000, 224'h0}, 32'hC1200000, 16'd0, 0, 0);
        add_vec(5, {32'hC0800000, 32'hC0400000, 32'hC0000000, 32'hBF800000, 32'hC0A00000, 96'h0},
                32'hBF800000, 16'd3, 0, 0);
        add_vec(3, {32'h00000000, 32'h80000000, 32'h00000000, 160'h0}, 32'h00000000, 16'd0, 0, 0);
        add_vec(6, {32'h3F000000, 32'h7F800000, 32'h42C80000, 32'hFF800000, 32'h7F7FFFFF,
                    32'h40000000, 64'h0}, 32'h7F800000, 16'd1, 0, 0);
        add_vec(3, {32'h40A00000, 32'h41200000, 32'h40E00000, 160'h0}, 32'h41200000, 16'd1, 2, 5);

        // Reset values while reset is held.
        step(); step();
        check("reset_outputs", 64'({bus.busy_o, bus.in_ready_o, bus.out_valid_o, 2'(bus.dbg_state)}),
              64'({1'b0, 1'b0, 1'b0, 2'(IDLE)}));
        check("reset_data", 64'({bus.out_data_o, bus.out_idx_o}), 64'd0);
        rst = 1'b0;
        step();

        foreach (vecs[k]) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Abort coinciding with the third of five handshakes.
        bus.start_i = 1'b1; bus.len_i = LW'(5);
        step();
        bus.start_i = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i = 32'h3F800000; step();
        bus.in_data_i = 32'h40000000; step();
        bus.in_data_i = 32'h7F000000; bus.abort_i = 1'b1; step();
        bus.abort_i = 1'b0; bus.in_valid_i = 1'b0;
        check("abort_idle", 64'({bus.busy_o, bus.in_ready_o, bus.out_valid_o, 2'(bus.dbg_state)}),
              64'({1'b0, 1'b0, 1'b0, 2'(IDLE)}));
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_output", 64'({bus.out_valid_o, bus.busy_o}), 64'd0);
        end
        add_vec(1, {32'h40400000, 224'h0}, 32'h40400000, 16'd0, 0, 0);
        run_vec(vecs[vecs.size()-1], "after_abort");

        // Abort while holding a result drops it.
        bus.start_i = 1'b1; bus.len_i = '0;
        step();
        bus.start_i = 1'b0;
        check("done_before_abort", 64'(bus.out_valid_o), 64'd1);
        bus.abort_i = 1'b1; step(); bus.abort_i = 1'b0;
        check("abort_in_done", 64'({bus.out_valid_o, bus.busy_o}), 64'd0);

        // Asynchronous reset mid-ACCUM.
        bus.start_i = 1'b1; bus.len_i = LW'(3);
        step();
        bus.start_i = 1'b0;
        bus.in_valid_i = 1'b1; bus.in_data_i = 32'h41000000;
        step();
        bus.in_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_reset_ctrl", 64'({bus.busy_o, bus.in_ready_o, bus.out_valid_o, 2'(bus.dbg_state)}),
              64'({1'b0, 1'b0, 1'b0, 2'(IDLE)}));
        check("async_reset_data", 64'({bus.out_data_o, bus.out_idx_o}), 64'd0);
        step(); step();
        rst = 1'b0;
        step();
        run_vec(vecs[0], "after_reset");

        // Full-length run: maximum planted at the last index.
        bus.start_i = 1'b1; bus.len_i = {LW{1'b1}};
        exp_q.push_back({32'h40000000, 16'hFFFE});
        step();
        bus.start_i = 1'b0;
        check("long_ready", 64'(bus.in_ready_o), 64'd1);
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            d = {1'b0, 8'($urandom_range(0, 126)), 23'($urandom)};
            bus.in_data_i = (i == 65534) ? 32'h40000000 : d;
            step();
        end
        bus.in_valid_i = 1'b0;
        collect("long_run");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
